// File: rtl/multdiv_divider.sv
// Iterative signed restoring divider, one quotient bit per clock; optional remainder port under `DIV_REMAINDER_EN.
// Latency: RDY high WIDTH+1 cycles after the start edge, or 1 cycle after it on divide-by-zero.
// No backpressure: the result is a one-cycle strobe, and a new ctrl_DIV aborts and restarts any operation in flight.
module multdiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
`ifdef DIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ZERO
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] babs_q, babs_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
`endif

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_step, q_step;

    // Magnitudes are unsigned, so |-2^(WIDTH-1)| is exactly 2^(WIDTH-1).
    assign a_abs = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign b_abs = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    // Partial remainder stays below |B| <= 2^(WIDTH-1), so its top bit is always zero
    // and the shifted value fits WIDTH+1 bits with the sign of the trial subtract on top.
    always_comb begin
        r_shift = {rem_q, quo_q[WIDTH-1]};
        diff    = r_shift - {1'b0, babs_q};
        if (!diff[WIDTH]) begin
            r_step = diff[WIDTH-1:0];
            q_step = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            r_step = r_shift[WIDTH-1:0];
            q_step = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        babs_d    = babs_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        res_d     = res_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
`ifdef DIV_REMAINDER_EN
        rem_out_d = rem_out_q;
`endif
        if (ctrl_DIV) begin
            // A start in any state discards whatever was in flight.
            if (data_operandB == '0) begin
                state_d   = S_ZERO;
                res_d     = '0;
                exc_d     = 1'b1;
                rdy_d     = 1'b1;
`ifdef DIV_REMAINDER_EN
                rem_out_d = data_operandA;
`endif
            end else begin
                state_d  = S_RUN;
                cnt_d    = '0;
                quo_d    = a_abs;
                rem_d    = '0;
                babs_d   = b_abs;
                sign_a_d = data_operandA[WIDTH-1];
                sign_b_d = data_operandB[WIDTH-1];
            end
        end else begin
            case (state_q)
                S_RUN: begin
                    quo_d = q_step;
                    rem_d = r_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d   = S_DONE;
                        res_d     = (sign_a_q ^ sign_b_q) ? (~q_step + 1'b1) : q_step;
                        exc_d     = 1'b0;
                        rdy_d     = 1'b1;
`ifdef DIV_REMAINDER_EN
                        rem_out_d = sign_a_q ? (~r_step + 1'b1) : r_step;
`endif
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ZERO:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            babs_q    <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            res_q     <= '0;
            exc_q     <= 1'b0;
            rdy_q     <= 1'b0;
`ifdef DIV_REMAINDER_EN
            rem_out_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            babs_q    <= babs_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            res_q     <= res_d;
            exc_q     <= exc_d;
            rdy_q     <= rdy_d;
`ifdef DIV_REMAINDER_EN
            rem_out_q <= rem_out_d;
`endif
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
`ifdef DIV_REMAINDER_EN
    assign data_remainder = rem_out_q;
`endif

endmodule

// File: tb/tb_multdiv_divider.sv
// Scoreboard bench for multdiv_divider: a driver queues model results, a monitor checks each RDY strobe.
// Covers reset mid-run, signs, divide-by-zero, corners, restart/abort and randomized operands.
module tb_multdiv_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef struct {
        logic [W-1:0] res;
        logic         exc;
        logic [W-1:0] rem;
        int           edge_n;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
`ifdef DIV_REMAINDER_EN
    logic [W-1:0] data_remainder;
`endif

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    exp_t         sb[$];
    logic [W-1:0] last_res = '0;

    multdiv_divider #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (opA),
        .data_operandB  (opB),
        .data_result    (data_result),
`ifdef DIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Reference: plain signed arithmetic, truncating toward zero, remainder follows the dividend.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.edge_n = 0;
        if (b == '0) begin
            e.res = '0;
            e.exc = 1'b1;
            e.rem = a;
        end else if (a == MIN_NEG && b == '1) begin
            e.res = MIN_NEG;
            e.exc = 1'b0;
            e.rem = '0;
        end else begin
            e.res = $signed(a) / $signed(b);
            e.exc = 1'b0;
            e.rem = $signed(a) % $signed(b);
        end
        return e;
    endfunction

    // Called at a negedge; returns one negedge later, after the start edge.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   c;
        c = cyc;
        while (sb.size() > 0 && sb[$].edge_n > c) void'(sb.pop_back());
        e = model(a, b);
        e.edge_n = c + 1 + ((b == '0) ? 0 : W);
        sb.push_back(e);
        ctrl_DIV = 1'b1;
        opA = a;
        opB = b;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        opA = $urandom;
        opB = $urandom;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = W'($urandom_range(0, 20));
            1: v = -W'($urandom_range(0, 20));
            2: v = MIN_NEG;
            3: v = ~MIN_NEG;
            4: v = W'($urandom_range(0, 1000));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (!reset_n) continue;
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rdy", 64'(data_resultRDY), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("rdy_cycle", 64'(cyc), 64'(e.edge_n));
                    chk("result", 64'(data_result), 64'(e.res));
                    chk("exception", 64'(data_exception), 64'(e.exc));
`ifdef DIV_REMAINDER_EN
                    chk("remainder", 64'(data_remainder), 64'(e.rem));
`endif
                    last_res = e.res;
                end
            end else begin
                if (sb.size() > 0 && sb[0].edge_n < cyc) begin
                    e = sb.pop_front();
                    chk("missing_rdy_cycle", 64'(cyc), 64'(e.edge_n));
                end
                chk("result_hold", 64'(data_result), 64'(last_res));
            end
        end
    end

    initial begin : driver
        logic [W-1:0] sa [0:8];
        logic [W-1:0] sbv[0:8];
        int k;
        sa[0] = -W'(100);  sbv[0] = W'(7);
        sa[1] = W'(100);   sbv[1] = -W'(7);
        sa[2] = -W'(100);  sbv[2] = -W'(7);
        sa[3] = W'(5);     sbv[3] = '0;
        sa[4] = MIN_NEG;   sbv[4] = '1;
        sa[5] = MIN_NEG;   sbv[5] = W'(1);
        sa[6] = '0;        sbv[6] = W'(9);
        sa[7] = W'(7);     sbv[7] = W'(9);
        sa[8] = '1;        sbv[8] = ~MIN_NEG;

        wait_neg(3);
        chk("reset_result", 64'(data_result), 64'(0));
        chk("reset_rdy", 64'(data_resultRDY), 64'(0));
        chk("reset_exception", 64'(data_exception), 64'(0));
        reset_n = 1'b1;
        wait_neg(1);

        // Reset partway through a division: nothing may come out of it.
        start(W'(100), W'(7));
        wait_neg(8);
        reset_n = 1'b0;
        sb.delete();
        last_res = '0;
        #1;
        chk("midrun_reset_result", 64'(data_result), 64'(0));
        chk("midrun_reset_rdy", 64'(data_resultRDY), 64'(0));
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(1);
        start(W'(100), W'(7));
        wait_neg(W + 1);

        for (int i = 0; i < 9; i++) begin
            start(sa[i], sbv[i]);
            wait_neg((sbv[i] == '0) ? 2 : W + 1);
        end

        start(W'(1000), W'(3));
        wait_neg(10);
        start(W'(50), W'(5));
        wait_neg(W + 2);

        for (int n = 0; n < 1200; n++) begin
            logic [W-1:0] a, b;
            int r;
            a = rand_operand();
            b = ($urandom_range(0, 15) == 0) ? '0 : rand_operand();
            start(a, b);
            r = $urandom_range(0, 9);
            if (r < 6)      k = W + 1 + $urandom_range(0, 2);
            else if (r < 8) k = W;
            else            k = $urandom_range(0, W - 1);
            wait_neg(k);
        end

        wait_neg(W + 4);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
